// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a registered carry, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a Sub port for A - B (two's complement via ~B and carry=1).
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] SUM,
  output logic             Carry_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, last, fa_s, fa_c;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  assign accept = (state_q != S_ADD) && Start;
  assign last   = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap = Sub ? ~B : B;
  assign c_cap = Sub ? 1'b1 : Carry_in;
`else
  assign b_cap = B;
  assign c_cap = Carry_in;
`endif

  serial_adder_fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_ADD;
      S_ADD:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = Start ? S_ADD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_ADD);
    Done = (state_q == S_DONE);
  end

  // SUM/Carry_out load only on the final ADD edge, so they hold across IDLE and the next ADD.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = A;
      b_d     = b_cap;
      carry_d = c_cap;
      cnt_d   = '0;
    end else if (state_q == S_ADD) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_c;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d  = {fa_s, res_q[WIDTH-1:1]};
        cout_d = fa_c;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign SUM       = sum_q;
  assign Carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit (WIDTH=8); Sub cases built when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_nbit;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Carry_in = 1'b0;
  logic         Sub = 1'b0;
  logic         Busy, Done, Carry_out;
  logic [W-1:0] SUM;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Carry_in  (Carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub       (Sub),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .SUM       (SUM),
    .Carry_out (Carry_out)
  );

  // Called at a negedge: present operands with Start, run until Done (bounded).
  // edges counts clock edges from the accept edge inclusive; returns at the negedge where Done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output int edges, output int busy_cnt);
    A = a; B = b; Carry_in = cin; Sub = sub; Start = 1'b1;
    edges = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); @(negedge Clk);
      Start = 1'b0;
      edges++;
      if (Busy) busy_cnt++;
      if (Done) break;
    end
    A = 'x; B = 'x; Carry_in = 1'bx;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (SUM !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", SUM); end
    checks++; if (Carry_out !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", Carry_out); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
    Reset_n = 1'b1;
    begin
      int seen = 0;
      repeat (6) begin @(negedge Clk); if (Done !== 1'b0 || Busy !== 1'b0) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL idle_no_done active_cycles=%0d exp=0", seen); end
    end
  endtask

  task automatic test_basic();
    int e, bc;
    do_op(8'h3C, 8'h0F, 1'b0, 1'b0, e, bc);
    checks++; if (e != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", e); end
    checks++; if (bc != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    checks++; if (SUM !== 8'h4B) begin failures++; $display("FAIL basic_sum got=%h exp=4B", SUM); end
    checks++; if (Carry_out !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", Carry_out); end
    @(negedge Clk);
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL done_strobe got=%b exp=0", Done); end
    checks++; if (SUM !== 8'h4B) begin failures++; $display("FAIL idle_hold_sum got=%h exp=4B", SUM); end
  endtask

  task automatic test_wrap();
    int e, bc;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, e, bc);
    checks++; if ({Carry_out, SUM} !== 9'h100) begin failures++; $display("FAIL wrap_ff_01 got=%b_%h exp=1_00", Carry_out, SUM); end
    @(negedge Clk);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, e, bc);
    checks++; if ({Carry_out, SUM} !== 9'h1FF) begin failures++; $display("FAIL wrap_allones got=%b_%h exp=1_FF", Carry_out, SUM); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int e, bc;
    do_op(8'h5A, 8'hA5, 1'b1, 1'b0, e, bc);
    checks++; if ({Carry_out, SUM} !== 9'h100) begin failures++; $display("FAIL b2b_first got=%b_%h exp=1_00", Carry_out, SUM); end
    // Still in DONE here: Start is raised again without an IDLE cycle.
    do_op(8'h01, 8'h01, 1'b0, 1'b0, e, bc);
    checks++; if (e != 9) begin failures++; $display("FAIL b2b_period got=%0d exp=9", e); end
    checks++; if ({Carry_out, SUM} !== 9'h002) begin failures++; $display("FAIL b2b_second got=%b_%h exp=0_02", Carry_out, SUM); end
    @(negedge Clk);
  endtask

  task automatic test_start_ignored();
    int e;
    A = 8'h3C; B = 8'h0F; Carry_in = 1'b0; Start = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Start = 1'b0; e = 1;
    A = 8'hFF; B = 8'hFF; Carry_in = 1'b1;
    repeat (3) begin Start = ~Start; @(posedge Clk); @(negedge Clk); e++; end
    checks++; if (SUM !== 8'h02 || Busy !== 1'b1) begin failures++; $display("FAIL add_hold_sum sum=%h busy=%b exp=02/1", SUM, Busy); end
    Start = 1'b1;
    for (int i = 0; i < 40 && !Done; i++) begin
      @(posedge Clk); @(negedge Clk); e++; Start = ~Start;
    end
    Start = 1'b0;
    checks++; if (e != 9) begin failures++; $display("FAIL ignore_latency got=%0d exp=9", e); end
    checks++; if ({Carry_out, SUM} !== 9'h04B) begin failures++; $display("FAIL ignore_result got=%b_%h exp=0_4B", Carry_out, SUM); end
    @(negedge Clk);
    if (Busy) @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    repeat (3) @(negedge Clk);
    A = 8'h12; B = 8'h34; Carry_in = 1'b0; Start = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Start = 1'b0;
    repeat (3) begin @(posedge Clk); @(negedge Clk); end
    Reset_n = 1'b0;
    #1;
    checks++; if ({Carry_out, SUM} !== 9'h000) begin failures++; $display("FAIL abort_result got=%b_%h exp=0_00", Carry_out, SUM); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL abort_flags busy=%b done=%b exp=0/0", Busy, Done); end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) begin @(negedge Clk); if (Done !== 1'b0 || Busy !== 1'b0) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done active_cycles=%0d exp=0", seen); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int e, bc;
    do_op(8'h10, 8'h01, 1'b0, 1'b1, e, bc);
    checks++; if ({Carry_out, SUM} !== 9'h10F) begin failures++; $display("FAIL sub_10_01 got=%b_%h exp=1_0F", Carry_out, SUM); end
    @(negedge Clk);
    do_op(8'h01, 8'h02, 1'b0, 1'b1, e, bc);
    checks++; if ({Carry_out, SUM} !== 9'h0FF) begin failures++; $display("FAIL sub_01_02 got=%b_%h exp=0_FF", Carry_out, SUM); end
    @(negedge Clk);
    Sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1);
  end
endmodule
